// File: rtl/riscv_loader_pkg.sv
// Shared definitions for the program loader: state encoding, the
// length-field width and the number of bytes packed into one word.
// The S_CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package riscv_loader_pkg;

    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK  = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory signals of the program loader.
// slave: the loader's view; master: the host / memory side.
interface program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader_word_packer.sv
// word_packer: collects little-endian bytes into 32-bit words and
// emits a one-cycle word_valid the cycle after the 4th byte arrives.
// clr_i synchronously drops any partially assembled word.
module word_packer
    import riscv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        last_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_q;
    logic        valid_q;
    logic [23:0] sr_q;
    logic [31:0] word_q;

    assign last_o       = (idx_q == LAST_IDX);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

    // Byte index and word strobe: control state, reset and clearable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= byte_vld_i && last_o;
            if (byte_vld_i) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    // Byte shift register and assembled word: earlier bytes land lower.
    always_ff @(posedge clk) begin
        if (byte_vld_i) begin
            sr_q <= {byte_i, sr_q[23:8]};
            if (last_o) begin
                word_q <= {byte_i, sr_q};
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives LEN_LO, LEN_HI and N little-endian words over
// a valid/ready byte stream, writes them to instruction memory from
// BASE_ADDR upward and releases the core reset once the load completes.
// Optional LOADER_CHECKSUM_EN: a trailing XOR byte over the whole stream
// is verified before the load is declared done.
module program_loader
    import riscv_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    program_loader_if.slave  bus,
    output logic             cpu_rst_n,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TERM = S_CHECK;
`else
    localparam state_t S_TERM = S_DONE;
`endif

    state_t             state_q, state_d;
    logic               rdy_en_q;
    logic [7:0]         len_lo_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [31:0]        addr_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         xor_q;
`endif

    logic               accept;
    logic               in_data;
    logic               word_inc;
    logic               last_word;
    logic [LEN_W-1:0]   n_full;
    logic               pk_last;
    logic               pk_valid;
    logic [31:0]        pk_word;

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign in_data   = (state_q == S_DATA);
    assign n_full    = {bus.rx_data, len_lo_q};
    assign last_word = (cnt_q + 16'd1 == len_q);
    assign word_inc  = accept && in_data && pk_last && (cnt_q != len_q);

    word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (!in_data),
        .byte_vld_i   (accept && in_data),
        .byte_i       (bus.rx_data),
        .last_o       (pk_last),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    // Ready is gated by rdy_en_q so it stays low through reset and rises
    // on the first edge afterwards.
    assign bus.rx_ready   = rdy_en_q && (state_q != S_DONE) && (state_q != S_ERROR);
    assign bus.imem_we    = pk_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = pk_word;
    assign done           = (state_q == S_DONE);
    assign cpu_rst_n      = (state_q == S_DONE);
    assign error          = (state_q == S_ERROR);
    assign words_loaded   = cnt_q;

    // Next-state logic for the stream parser.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LEN_LO: if (accept) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (32'(n_full) > MAX_WORDS) state_d = S_ERROR;
                    else if (n_full != '0)       state_d = S_DATA;
                    else                         state_d = S_TERM;
                end
            end
            S_DATA: if (accept && pk_last && last_word) state_d = S_TERM;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) state_d = (bus.rx_data == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // State register, ready enable and saturating word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_LEN_LO;
            rdy_en_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (word_inc) cnt_q <= cnt_q + 16'd1;
        end
    end

    // Length capture and the write address for the word being completed.
    always_ff @(posedge clk) begin
        if (accept && state_q == S_LEN_LO) len_lo_q <= bus.rx_data;
        if (accept && state_q == S_LEN_HI) len_q    <= n_full;
        if (word_inc) addr_q <= BASE_ADDR + 32'(cnt_q) * BYTES_PER_WORD;
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every accepted byte, restarted by LEN_LO.
    always_ff @(posedge clk) begin
        if (accept) xor_q <= (state_q == S_LEN_LO) ? bus.rx_data : (xor_q ^ bus.rx_data);
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader. Expected memory writes
// are derived from the byte stream by a reference model and queued; a
// monitor pops and compares on every imem_we.
module tb_program_loader;
    import riscv_loader_pkg::*;

    localparam int unsigned MAX_W = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rst_n, done, error;
    logic [15:0] words_loaded;

    program_loader_if bus ();

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    wr_t  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        chk("done_error_exclusive", {31'd0, done & error}, 32'd0);
        if (bus.imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", bus.imem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("imem_addr", bus.imem_addr, e.addr);
                chk("imem_wdata", bus.imem_wdata, e.data);
            end
        end
    end

    // Reference model: interprets the bytes actually sent, queues the
    // writes they must produce and predicts the final outcome.
    task automatic model(input bq_t s, output bit e_done, output bit e_err, output int e_words);
        int n, avail;
        e_done = 0; e_err = 0; e_words = 0;
        if (s.size() < 2) return;
        n = int'(s[0]) + 256 * int'(s[1]);
        if (n > int'(MAX_W)) begin
            e_err = 1;
            return;
        end
        avail   = (s.size() - 2) / 4;
        e_words = (n < avail) ? n : avail;
        for (int k = 0; k < e_words; k++) begin
            wr_t w;
            w.addr = BASE + 32'(4 * k);
            w.data = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
            exp_q.push_back(w);
        end
`ifdef LOADER_CHECKSUM_EN
        if (s.size() >= 3 + 4 * n) begin
            logic [7:0] x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x ^= s[i];
            if (s[2+4*n] == x) e_done = 1;
            else               e_err  = 1;
        end
`else
        if (s.size() >= 2 + 4 * n) e_done = 1;
`endif
    endtask

    function automatic bq_t with_ck(input bq_t s);
        bq_t r = s;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (s[i]) x ^= s[i];
        r.push_back(x);
`endif
        return r;
    endfunction

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_words_loaded", {16'd0, words_loaded}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("ready_low_after_release", {31'd0, bus.rx_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_first_edge", {31'd0, bus.rx_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        bit xfer;
        int budget;
        ok = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        budget = 0;
        do begin
            xfer = bus.rx_ready;
            @(posedge clk); #1;
            budget++;
        end while (!xfer && budget < 50);
        bus.rx_valid = 1'b0;
        ok = xfer;
    endtask

    task automatic send_bytes(input bq_t s, input bit gaps);
        bit ok;
        foreach (s[i]) begin
            send_byte(s[i], gaps, ok);
            if (!ok) begin
                chk("byte_accept_timeout", 32'(i), 32'hFFFF_FFFF);
                return;
            end
        end
    endtask

    task automatic run_stream(input string tag, input bq_t s, input bit gaps);
        bit e_done, e_err;
        int e_words, budget;
        do_reset();
        model(s, e_done, e_err, e_words);
        send_bytes(s, gaps);
        budget = 0;
        while (!(done || error) && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        @(posedge clk); #1;
        chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, e_done});
        chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
        chk({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'(e_words));
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bq_t s, p;
        bit  d0, d1;
        int  w0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Two-word program, one byte per cycle.
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_stream("two_words", with_ck(s), 1'b0);

        // Empty program.
        s = '{8'h00, 8'h00};
        run_stream("empty", with_ck(s), 1'b1);

        // Length one past capacity.
        s = '{8'h01, 8'h01};
        run_stream("too_long", s, 1'b0);

        // Three words, gap-free then with random valid gaps.
        s = '{8'h03, 8'h00};
        for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
        run_stream("three_nogap", with_ck(s), 1'b0);
        run_stream("three_gaps", with_ck(s), 1'b1);

        // Reset after 6 of 8 data bytes, then a full reload.
        s = '{8'h02, 8'h00};
        for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
        do_reset();
        p = s[0:7];
        model(p, d0, d1, w0);
        send_bytes(p, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("partial_first_word_written", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midload_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("midload_imem_we", {31'd0, bus.imem_we}, 32'd0);
        chk("midload_words_loaded", {16'd0, words_loaded}, 32'd0);
        chk("midload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        run_stream("reload", with_ck(s), 1'b0);

        // Random loads of assorted lengths.
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 6);
            s = '{8'(n), 8'h00};
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
            run_stream("random", with_ck(s), 1'($urandom_range(0, 1)));
        end

        // Exactly at capacity.
        s = '{8'h00, 8'h01};
        for (int i = 0; i < 4 * int'(MAX_W); i++) s.push_back(8'($urandom));
        run_stream("full_capacity", with_ck(s), 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum: writes still happen, then error.
        s = with_ck('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
        s[s.size()-1] ^= 8'h01;
        run_stream("bad_checksum", s, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
